caxi4interconnect_dwc_upconv_rchan_mst_beat_mux: RTL and testbench

- Sits directly downstream of the up-converter read-data arbiter, which produces one-hot active-low grant_n over per-ID slave data FIFOs.
- Selects the granted FIFO and splits each wide slave word into narrow master beats (one lane per beat).
- Drives the master R channel, pops the FIFO after the last lane of each word, and returns per-ID arb_ctrl (RVALID one-hot) to the arbiter.

---
 rtl/caxi4interconnect_dwc_upconv_rchan_mst_beat_mux_pkg.sv | 29 ++
 rtl/caxi4interconnect_dwc_onehot2bin.sv | 20 ++
 rtl/caxi4interconnect_dwc_upconv_rchan_mst_beat_mux.sv | 149 ++++++++++++++
 tb/tb_caxi4interconnect_dwc_upconv_rchan_mst_beat_mux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/caxi4interconnect_dwc_upconv_rchan_mst_beat_mux_pkg.sv
// Shared definitions for the DWC up-converter channels: AXI response codes
// and the slave/master width ratio and lane-index derivation.
package caxi4interconnect_dwc_upconv_rchan_mst_beat_mux_pkg;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  function automatic int dwc_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int dwc_ratio(input int slv_w, input int mst_w);
    return slv_w / mst_w;
  endfunction

  // Width of a lane index; never below one bit so ports stay legal.
  function automatic int dwc_lane_w(input int ratio);
    return (dwc_clog2(ratio) < 1) ? 1 : dwc_clog2(ratio);
  endfunction

endpackage

// File: rtl/caxi4interconnect_dwc_onehot2bin.sv
// Active-low one-hot to binary encoder; 'none' flags an all-ones input.
module caxi4interconnect_dwc_onehot2bin #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] onehot_n,
  output logic [W-1:0] bin,
  output logic         none
);

  // OR-reduction encode: exact for a legal one-hot input.
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++)
      if (!onehot_n[i]) bin = bin | W'(i);
  end

  assign none = &onehot_n;

endmodule

// File: rtl/caxi4interconnect_dwc_upconv_rchan_mst_beat_mux.sv
// Up-converter read path: picks the granted per-ID FIFO, splits each wide
// slave word into narrow master R beats and pops after the last lane.
module caxi4interconnect_dwc_upconv_rchan_mst_beat_mux
  import caxi4interconnect_dwc_upconv_rchan_mst_beat_mux_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int TOTAL_IDS      = 2**ID_WIDTH,
  parameter int MST_DATA_WIDTH = 32,
  parameter int SLV_DATA_WIDTH = 64,
  parameter int USER_WIDTH     = 1,
  localparam int RATIO  = dwc_ratio(SLV_DATA_WIDTH, MST_DATA_WIDTH),
  localparam int LANE_W = dwc_lane_w(RATIO)
) (
  input  logic                                ACLK,
  input  logic                                sysReset,
  input  logic [TOTAL_IDS-1:0]                grant_n,
  input  logic [TOTAL_IDS-1:0]                fifo_empty,
  input  logic [TOTAL_IDS*SLV_DATA_WIDTH-1:0] fifo_rdata,
  input  logic [TOTAL_IDS*LANE_W-1:0]         fifo_start,
  input  logic [TOTAL_IDS*LANE_W-1:0]         fifo_end,
  input  logic [TOTAL_IDS-1:0]                fifo_last,
  input  logic [TOTAL_IDS*2-1:0]              fifo_resp,
  input  logic [TOTAL_IDS*USER_WIDTH-1:0]     fifo_ruser,
  output logic [TOTAL_IDS-1:0]                fifo_rd_en,
  output logic [ID_WIDTH-1:0]                 MASTER_RID,
  output logic [MST_DATA_WIDTH-1:0]           MASTER_RDATA,
  output logic [1:0]                          MASTER_RRESP,
  output logic                                MASTER_RLAST,
  output logic [USER_WIDTH-1:0]               MASTER_RUSER,
  output logic                                MASTER_RVALID,
  input  logic                                MASTER_RREADY,
  output logic [TOTAL_IDS-1:0]                arb_ctrl
);

  logic [RATIO-1:0][MST_DATA_WIDTH-1:0] rdata_a [TOTAL_IDS];
  logic [LANE_W-1:0]     start_a [TOTAL_IDS];
  logic [LANE_W-1:0]     end_a   [TOTAL_IDS];
  logic [1:0]            resp_a  [TOTAL_IDS];
  logic [USER_WIDTH-1:0] ruser_a [TOTAL_IDS];

  for (genvar g = 0; g < TOTAL_IDS; g++) begin : g_unpack
    assign rdata_a[g] = fifo_rdata[g*SLV_DATA_WIDTH +: SLV_DATA_WIDTH];
    assign start_a[g] = fifo_start[g*LANE_W +: LANE_W];
    assign end_a[g]   = fifo_end[g*LANE_W +: LANE_W];
    assign resp_a[g]  = fifo_resp[g*2 +: 2];
    assign ruser_a[g] = fifo_ruser[g*USER_WIDTH +: USER_WIDTH];
  end

  logic [ID_WIDTH-1:0] sel_id;
  logic                no_gnt;

  caxi4interconnect_dwc_onehot2bin #(.N(TOTAL_IDS), .W(ID_WIDTH)) u_gnt_enc (
    .onehot_n (grant_n),
    .bin      (sel_id),
    .none     (no_gnt)
  );

  logic [ID_WIDTH-1:0]       rid_q,   rid_d;
  logic [MST_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rlast_q, rlast_d;
  logic [USER_WIDTH-1:0]     ruser_q, ruser_d;
  logic                      rvalid_q, rvalid_d;
  logic [LANE_W-1:0]         lane_ptr_q, lane_ptr_d;
  logic                      ptr_vld_q, ptr_vld_d;

  logic              src_av, load, word_done;
  logic [LANE_W-1:0] cur_lane;

  always_comb begin
    src_av    = ~no_gnt & ~fifo_empty[sel_id];
    // Mid-word the lane pointer owns the position; a fresh word starts at
    // its own start lane, which may sit above its end lane for wraps.
    cur_lane  = ptr_vld_q ? lane_ptr_q : start_a[sel_id];
    word_done = (cur_lane == end_a[sel_id]);
    load      = src_av & (~rvalid_q | MASTER_RREADY);

    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    ruser_d    = ruser_q;
    rvalid_d   = rvalid_q;
    lane_ptr_d = lane_ptr_q;
    ptr_vld_d  = ptr_vld_q;
    fifo_rd_en = '0;

    if (load) begin
      rid_d    = sel_id;
      rdata_d  = rdata_a[sel_id][cur_lane];
      rresp_d  = resp_a[sel_id];
      ruser_d  = ruser_a[sel_id];
      rlast_d  = fifo_last[sel_id] & word_done;
      rvalid_d = 1'b1;
      if (word_done) begin
        fifo_rd_en[sel_id] = 1'b1;
        ptr_vld_d          = 1'b0;
      end else begin
        lane_ptr_d = LANE_W'(cur_lane + 1'b1);
        ptr_vld_d  = 1'b1;
      end
    end else if (rvalid_q & MASTER_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RRESP_OKAY;
      rlast_q    <= 1'b0;
      ruser_q    <= '0;
      rvalid_q   <= 1'b0;
      lane_ptr_q <= '0;
      ptr_vld_q  <= 1'b0;
    end else begin
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      ruser_q    <= ruser_d;
      rvalid_q   <= rvalid_d;
      lane_ptr_q <= lane_ptr_d;
      ptr_vld_q  <= ptr_vld_d;
    end
  end

  // The arbiter holds an ID until its beat drains; this is its feedback.
  always_comb begin
    arb_ctrl = '0;
    if (rvalid_q) arb_ctrl[rid_q] = 1'b1;
  end

  assign MASTER_RID    = rid_q;
  assign MASTER_RDATA  = rdata_q;
  assign MASTER_RRESP  = rresp_q;
  assign MASTER_RLAST  = rlast_q;
  assign MASTER_RUSER  = ruser_q;
  assign MASTER_RVALID = rvalid_q;

  a_gnt_onehot: assert property (@(posedge ACLK) disable iff (!sysReset)
    $onehot0(~grant_n));
  a_gnt_stable: assert property (@(posedge ACLK) disable iff (!sysReset)
    ptr_vld_q |-> (grant_n == $past(grant_n)));
  a_pop_nonempty: assert property (@(posedge ACLK) disable iff (!sysReset)
    (fifo_rd_en & fifo_empty) == '0);

endmodule

// File: tb/tb_caxi4interconnect_dwc_upconv_rchan_mst_beat_mux.sv
// Scoreboard bench: per-ID FIFO and arbiter models feed the beat mux, and
// every accepted beat is checked against beats queued when words are pushed.
module tb_caxi4interconnect_dwc_upconv_rchan_mst_beat_mux;
  localparam int IDW = 2, NID = 4, MW = 32, SW = 128, UW = 1, R = 4, LW = 2;

  logic              ACLK = 1'b0;
  logic              sysReset;
  logic [NID-1:0]    grant_n, fifo_empty, fifo_last, fifo_rd_en, arb_ctrl;
  logic [NID*SW-1:0] fifo_rdata;
  logic [NID*LW-1:0] fifo_start, fifo_end;
  logic [NID*2-1:0]  fifo_resp;
  logic [NID*UW-1:0] fifo_ruser;
  logic [IDW-1:0]    MASTER_RID;
  logic [MW-1:0]     MASTER_RDATA;
  logic [1:0]        MASTER_RRESP;
  logic              MASTER_RLAST, MASTER_RVALID, MASTER_RREADY;
  logic [UW-1:0]     MASTER_RUSER;

  always #5 ACLK = ~ACLK;

  caxi4interconnect_dwc_upconv_rchan_mst_beat_mux #(
    .ID_WIDTH(IDW), .MST_DATA_WIDTH(MW), .SLV_DATA_WIDTH(SW), .USER_WIDTH(UW)
  ) dut (
    .ACLK(ACLK), .sysReset(sysReset), .grant_n(grant_n), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_start(fifo_start), .fifo_end(fifo_end),
    .fifo_last(fifo_last), .fifo_resp(fifo_resp), .fifo_ruser(fifo_ruser),
    .fifo_rd_en(fifo_rd_en), .MASTER_RID(MASTER_RID), .MASTER_RDATA(MASTER_RDATA),
    .MASTER_RRESP(MASTER_RRESP), .MASTER_RLAST(MASTER_RLAST),
    .MASTER_RUSER(MASTER_RUSER), .MASTER_RVALID(MASTER_RVALID),
    .MASTER_RREADY(MASTER_RREADY), .arb_ctrl(arb_ctrl)
  );

  typedef struct packed {
    logic [SW-1:0] data; logic [LW-1:0] st; logic [LW-1:0] en;
    logic last; logic [1:0] resp; logic [UW-1:0] user;
  } fw_t;
  typedef struct packed {
    logic [MW-1:0] data; logic [1:0] resp; logic [UW-1:0] user; logic last;
  } bt_t;

  fw_t fq[NID][$];
  bt_t exq[NID][$];
  int  checks = 0, failures = 0;
  int  rem[NID];
  logic m_vld, g_vld, hold_prev;
  logic [IDW-1:0] m_id, g_id, held_id;
  bt_t held;
  int  rr_hold = 0;
  bit  rnd_rr = 0;

  task automatic chk(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int nl(input fw_t w);
    logic [LW-1:0] d;
    d = w.en - w.st;
    return int'(d) + 1;
  endfunction

  task automatic gen_beats(input int id, input fw_t w);
    logic [LW-1:0] l;
    bt_t b;
    l = w.st;
    for (int k = 0; k < R; k++) begin
      b.data = w.data[int'(l)*MW +: MW];
      b.resp = w.resp; b.user = w.user;
      b.last = w.last && (l == w.en);
      exq[id].push_back(b);
      if (l == w.en) break;
      l = l + 1'b1;
    end
  endtask

  task automatic drive_fifo();
    fw_t w;
    for (int i = 0; i < NID; i++) begin
      w = '0;
      fifo_empty[i] = (fq[i].size() == 0);
      if (fq[i].size() > 0) w = fq[i][0];
      fifo_rdata[i*SW +: SW] = w.data;
      fifo_start[i*LW +: LW] = w.st;
      fifo_end[i*LW +: LW]   = w.en;
      fifo_last[i]           = w.last;
      fifo_resp[i*2 +: 2]    = w.resp;
      fifo_ruser[i*UW +: UW] = w.user;
    end
    grant_n = '1;
    if (g_vld) grant_n[g_id] = 1'b0;
  endtask

  task automatic push_word(input int id, input logic [SW-1:0] d, input logic [LW-1:0] st,
                           input logic [LW-1:0] en, input logic last, input logic [1:0] resp,
                           input logic [UW-1:0] user);
    fw_t w;
    w = '{data: d, st: st, en: en, last: last, resp: resp, user: user};
    fq[id].push_back(w);
    gen_beats(id, w);
    drive_fifo();
  endtask

  task automatic tick();
    logic [NID-1:0] rd, exp_pop;
    logic rr, ld;
    bt_t b;
    @(posedge ACLK);
    rd = fifo_rd_en; rr = MASTER_RREADY; exp_pop = '0;
    ld = g_vld && (fq[g_id].size() > 0) && (!m_vld || rr);
    if (ld) begin
      if (rem[g_id] == 0) rem[g_id] = nl(fq[g_id][0]);
      rem[g_id]--;
      if (rem[g_id] == 0) exp_pop[g_id] = 1'b1;
      m_vld = 1'b1; m_id = g_id;
    end else if (m_vld && rr) m_vld = 1'b0;
    chk("rd_en", rd, exp_pop);
    #1;
    for (int i = 0; i < NID; i++)
      if (exp_pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    if (g_vld && fq[g_id].size() == 0 && !(m_vld && m_id == g_id)) g_vld = 1'b0;
    for (int i = 0; i < NID; i++)
      if (!g_vld && fq[i].size() > 0) begin g_vld = 1'b1; g_id = IDW'(i); end
    drive_fifo();
    @(negedge ACLK);
    chk("rvalid", MASTER_RVALID, m_vld);
    chk("arb_ctrl", arb_ctrl, m_vld ? (4'b0001 << m_id) : 4'b0000);
    if (hold_prev) begin
      chk("hold_data", MASTER_RDATA, held.data);
      chk("hold_id", MASTER_RID, held_id);
      chk("hold_last", MASTER_RLAST, held.last);
    end
    if (rr_hold > 0) begin MASTER_RREADY = 1'b0; rr_hold--; end
    else MASTER_RREADY = rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1;
    if (m_vld && MASTER_RREADY) begin
      chk("rid", MASTER_RID, m_id);
      if (exq[m_id].size() == 0) chk("extra_beat", 1, 0);
      else begin
        b = exq[m_id].pop_front();
        chk("rdata", MASTER_RDATA, b.data);
        chk("rresp", MASTER_RRESP, b.resp);
        chk("ruser", MASTER_RUSER, b.user);
        chk("rlast", MASTER_RLAST, b.last);
      end
    end
    hold_prev = m_vld && !MASTER_RREADY;
    held = '{data: MASTER_RDATA, resp: MASTER_RRESP, user: MASTER_RUSER, last: MASTER_RLAST};
    held_id = MASTER_RID;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NID; i++)
      if (fq[i].size() > 0 || exq[i].size() > 0) return 1'b1;
    return m_vld;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin tick(); n++; end
    if (busy()) chk("drain_timeout", 1, 0);
  endtask

  task automatic model_reset();
    m_vld = 1'b0; g_vld = 1'b0; hold_prev = 1'b0; m_id = '0; g_id = '0;
    for (int i = 0; i < NID; i++) rem[i] = 0;
  endtask

  initial begin
    logic [SW-1:0] d;
    model_reset();
    sysReset = 1'b0; MASTER_RREADY = 1'b1;
    drive_fifo();
    repeat (3) @(negedge ACLK);
    chk("rst_rvalid", MASTER_RVALID, 0);
    chk("rst_arb", arb_ctrl, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_rdata", MASTER_RDATA, 0);
    chk("rst_rlast", MASTER_RLAST, 0);
    sysReset = 1'b1;
    tick();

    // Basic split
    push_word(0, {64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA}, 2'd0, 2'd1, 1'b1, 2'b00, 1'b1);
    drain(50);

    // Backpressure on the first beat
    push_word(0, {64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA}, 2'd0, 2'd1, 1'b1, 2'b01, 1'b0);
    rr_hold = 3;
    drain(50);

    // Wrap: lanes 3,0,1
    push_word(0, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0},
              2'd3, 2'd1, 1'b1, 2'b10, 1'b1);
    drain(50);

    // Single lane
    push_word(0, {32'h3, 32'hC2C2C2C2, 32'h1, 32'h0}, 2'd2, 2'd2, 1'b0, 2'b00, 1'b0);
    tick();
    chk("single_ptr_vld", dut.ptr_vld_q, 0);
    drain(50);

    // Interleave across IDs with random backpressure
    rnd_rr = 1'b1;
    push_word(1, {32'h14, 32'h13, 32'h12, 32'h11}, 2'd0, 2'd3, 1'b0, 2'b00, 1'b0);
    push_word(1, {32'h24, 32'h23, 32'h22, 32'h21}, 2'd1, 2'd2, 1'b1, 2'b00, 1'b1);
    push_word(2, {32'h34, 32'h33, 32'h32, 32'h31}, 2'd2, 2'd0, 1'b1, 2'b11, 1'b0);
    drain(200);

    // Random words
    for (int k = 0; k < 16; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      push_word(int'($urandom_range(0, NID-1)), d, 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain(600);
    rnd_rr = 1'b0;

    // Reset mid-word: beat discarded, head word replays from its start lane
    push_word(3, {32'h44, 32'h43, 32'h42, 32'h41}, 2'd0, 2'd3, 1'b1, 2'b00, 1'b1);
    tick();
    tick();
    sysReset = 1'b0;
    #1;
    chk("mid_rst_rvalid", MASTER_RVALID, 0);
    chk("mid_rst_arb", arb_ctrl, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    model_reset();
    exq[3].delete();
    foreach (fq[3][k]) gen_beats(3, fq[3][k]);
    drive_fifo();
    @(negedge ACLK);
    sysReset = 1'b1;
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
